axi_rd_line_fill: RTL and testbench

AXI_RD_LINE_FILL -- requirements
Module: axi_rd_line_fill

---
 rtl/axi_rd_line_fill.sv | 181 ++++++++++++++++++
 tb/tb_axi_rd_line_fill.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_line_fill.sv
// Line-fill read engine: issues one AXI-style read burst (full line or single beat)
// through a request/grant shim and assembles the returned beats into a line buffer.
module axi_rd_line_fill #(
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned AxiNumWords  = 4,
    localparam int unsigned BlenW = $clog2(AxiNumWords),
    localparam int unsigned LineW = AxiNumWords * AxiDataWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    req_ready_o,
    input  logic [AxiAddrWidth-1:0] req_addr_i,
    input  logic                    req_single_i,
    input  logic [AxiIdWidth-1:0]   req_id_i,
    output logic                    line_valid_o,
    input  logic                    line_ready_i,
    output logic [LineW-1:0]        line_data_o,
    output logic                    line_err_o,
    output logic                    rd_req_o,
    input  logic                    rd_gnt_i,
    output logic [AxiAddrWidth-1:0] rd_addr_o,
    output logic [BlenW-1:0]        rd_blen_o,
    output logic [2:0]              rd_size_o,
    output logic [AxiIdWidth-1:0]   rd_id_o,
    output logic                    rd_lock_o,
    output logic                    rd_rdy_o,
    input  logic                    rd_valid_i,
    input  logic                    rd_last_i,
    input  logic [AxiDataWidth-1:0] rd_data_i,
    input  logic [AxiIdWidth-1:0]   rd_id_i
);

    localparam int unsigned WordOffW = $clog2(AxiDataWidth / 8);
    localparam int unsigned LineOffW = $clog2(LineW / 8);
    localparam logic [AxiAddrWidth-1:0] WordMask = {AxiAddrWidth{1'b1}} << WordOffW;
    localparam logic [AxiAddrWidth-1:0] LineMask = {AxiAddrWidth{1'b1}} << LineOffW;
    localparam logic [2:0]       RdSize   = 3'(WordOffW);
    localparam logic [BlenW-1:0] LineBlen = BlenW'(AxiNumWords - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] AR   = 2'd1;
    localparam logic [1:0] R    = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [AxiAddrWidth-1:0] addr_q, addr_d;
    logic [BlenW-1:0]        blen_q, blen_d;
    logic [AxiIdWidth-1:0]   id_q, id_d;
    logic [BlenW-1:0]        start_q, start_d;
    logic [BlenW-1:0]        cnt_q, cnt_d;
    logic [LineW-1:0]        line_q, line_d;
    logic                    err_q, err_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rd_req_q, rd_req_d;
    logic                    rd_rdy_q, rd_rdy_d;
    logic                    line_valid_q, line_valid_d;
    logic                    beat_hit_s;
    logic [BlenW-1:0]        widx_s;

    // Next-state, capture and beat-assembly logic; handshake flags follow the next state.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        blen_d     = blen_q;
        id_d       = id_q;
        start_d    = start_q;
        cnt_d      = cnt_q;
        line_d     = line_q;
        err_d      = err_q;
        beat_hit_s = rd_valid_i && (rd_id_i == id_q);
        widx_s     = start_q + cnt_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = AR;
                    id_d    = req_id_i;
                    cnt_d   = '0;
                    line_d  = '0;
                    err_d   = 1'b0;
                    if (req_single_i) begin
                        addr_d  = req_addr_i & WordMask;
                        blen_d  = '0;
                        start_d = req_addr_i[LineOffW-1:WordOffW];
                    end else begin
                        addr_d  = req_addr_i & LineMask;
                        blen_d  = LineBlen;
                        start_d = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            AR: begin
                if (rd_gnt_i) begin
                    state_d = R;
                end else begin
                    state_d = AR;
                end
            end
            R: begin
                // Foreign-id beats are accepted on the bus but leave no trace here.
                if (beat_hit_s) begin
                    line_d[widx_s*AxiDataWidth +: AxiDataWidth] = rd_data_i;
                    cnt_d = cnt_q + BlenW'(1);
                    if (cnt_q == blen_q) begin
                        state_d = DONE;
                        err_d   = err_q | ~rd_last_i;
                    end else if (rd_last_i) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = R;
                    end
                end else begin
                    state_d = R;
                end
            end
            DONE: begin
                if (line_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_ready_d  = (state_d == IDLE);
        rd_req_d     = (state_d == AR);
        rd_rdy_d     = (state_d == R);
        line_valid_d = (state_d == DONE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            blen_q       <= '0;
            id_q         <= '0;
            start_q      <= '0;
            cnt_q        <= '0;
            line_q       <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_rdy_q     <= 1'b0;
            line_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            blen_q       <= blen_d;
            id_q         <= id_d;
            start_q      <= start_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            rd_req_q     <= rd_req_d;
            rd_rdy_q     <= rd_rdy_d;
            line_valid_q <= line_valid_d;
        end
    end

    assign req_ready_o  = req_ready_q;
    assign line_valid_o = line_valid_q;
    assign line_data_o  = line_q;
    assign line_err_o   = err_q;
    assign rd_req_o     = rd_req_q;
    assign rd_addr_o    = addr_q;
    assign rd_blen_o    = blen_q;
    assign rd_size_o    = RdSize;
    assign rd_id_o      = id_q;
    assign rd_lock_o    = 1'b0;
    assign rd_rdy_o     = rd_rdy_q;

endmodule

// File: tb/tb_axi_rd_line_fill.sv
// Randomized bench for axi_rd_line_fill: transaction-level model of the expected
// handshake phase, request fields and assembled line, checked every cycle.
module tb_axi_rd_line_fill;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int LW = N * W;
    localparam int PH_IDLE = 0;
    localparam int PH_AR   = 1;
    localparam int PH_R    = 2;
    localparam int PH_DONE = 3;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b1;
    logic          req_i = 1'b0;
    logic          req_ready_o;
    logic [63:0]   req_addr_i = '0;
    logic          req_single_i = 1'b0;
    logic [3:0]    req_id_i = '0;
    logic          line_valid_o;
    logic          line_ready_i = 1'b0;
    logic [LW-1:0] line_data_o;
    logic          line_err_o;
    logic          rd_req_o;
    logic          rd_gnt_i = 1'b0;
    logic [63:0]   rd_addr_o;
    logic [1:0]    rd_blen_o;
    logic [2:0]    rd_size_o;
    logic [3:0]    rd_id_o;
    logic          rd_lock_o;
    logic          rd_rdy_o;
    logic          rd_valid_i = 1'b0;
    logic          rd_last_i = 1'b0;
    logic [63:0]   rd_data_i = '0;
    logic [3:0]    rd_id_i = '0;

    always #5 clk = ~clk;

    axi_rd_line_fill #(
        .AxiAddrWidth(64), .AxiDataWidth(64), .AxiIdWidth(4), .AxiNumWords(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_single_i(req_single_i), .req_id_i(req_id_i),
        .line_valid_o(line_valid_o), .line_ready_i(line_ready_i),
        .line_data_o(line_data_o), .line_err_o(line_err_o),
        .rd_req_o(rd_req_o), .rd_gnt_i(rd_gnt_i), .rd_addr_o(rd_addr_o),
        .rd_blen_o(rd_blen_o), .rd_size_o(rd_size_o), .rd_id_o(rd_id_o),
        .rd_lock_o(rd_lock_o), .rd_rdy_o(rd_rdy_o), .rd_valid_i(rd_valid_i),
        .rd_last_i(rd_last_i), .rd_data_i(rd_data_i), .rd_id_i(rd_id_i)
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          ph = PH_IDLE;
    bit          chk_en = 1'b0;
    logic [63:0] exp_addr = '0;
    logic [1:0]  exp_blen = '0;
    logic [3:0]  exp_id = '0;
    logic [63:0] exp_line [N];
    logic        exp_err = 1'b0;

    logic [63:0]   snap_addr;
    logic [1:0]    snap_blen;
    logic [LW-1:0] snap_line;
    logic [LW-1:0] snap_model;
    logic          snap_err;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] exp_pack();
        logic [LW-1:0] p;
        for (int k = 0; k < N; k++) p[k*W +: W] = exp_line[k];
        return p;
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready",  256'(req_ready_o),  256'(ph == PH_IDLE));
            chk("rd_req",     256'(rd_req_o),     256'(ph == PH_AR));
            chk("rd_rdy",     256'(rd_rdy_o),     256'(ph == PH_R));
            chk("line_valid", 256'(line_valid_o), 256'(ph == PH_DONE));
            chk("rd_lock",    256'(rd_lock_o),    256'(1'b0));
            chk("rd_size",    256'(rd_size_o),    256'(3'd3));
            if (ph != PH_IDLE) begin
                chk("rd_addr", 256'(rd_addr_o), 256'(exp_addr));
                chk("rd_blen", 256'(rd_blen_o), 256'(exp_blen));
                chk("rd_id",   256'(rd_id_o),   256'(exp_id));
            end
            if (ph == PH_DONE) begin
                chk("line_data", 256'(line_data_o), 256'(exp_pack()));
                chk("line_err",  256'(line_err_o),  256'(exp_err));
            end
        end
    end

    task automatic zero_check(input string tag);
        chk({tag, "_line_valid"}, 256'(line_valid_o), 256'(1'b0));
        chk({tag, "_rd_req"},     256'(rd_req_o),     256'(1'b0));
        chk({tag, "_rd_rdy"},     256'(rd_rdy_o),     256'(1'b0));
        chk({tag, "_rd_addr"},    256'(rd_addr_o),    256'(64'h0));
        chk({tag, "_rd_blen"},    256'(rd_blen_o),    256'(2'd0));
        chk({tag, "_rd_id"},      256'(rd_id_o),      256'(4'd0));
        chk({tag, "_line_data"},  256'(line_data_o),  256'(0));
        chk({tag, "_line_err"},   256'(line_err_o),   256'(1'b0));
    endtask

    task automatic reset_pulse(input string tag);
        chk_en = 1'b0;
        rd_valid_i = 1'b0;
        rd_gnt_i = 1'b0;
        req_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        zero_check(tag);
        @(posedge clk);
        #2;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        ph = PH_IDLE;
        chk_en = 1'b1;
        chk({tag, "_ready_after"}, 256'(req_ready_o), 256'(1'b1));
    endtask

    task automatic run_txn(input logic [63:0] addr, input bit single, input logic [3:0] id,
                           input logic [3:0] fid, input int gnt_dly, input int fpos,
                           input int early, input bit drop_last, input int hold,
                           input bit rst2, input bit poke, input bit gaps,
                           input logic [63:0] d0);
        int n;
        int start;
        int k;
        int cyc;
        bit done;
        bit fsent;
        bit own;
        bit l;
        n = single ? 1 : N;
        start = single ? int'(addr[4:3]) : 0;
        req_i = 1'b1;
        req_addr_i = addr;
        req_single_i = single;
        req_id_i = id;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        exp_addr = single ? (addr & ~64'h7) : (addr & ~64'h1F);
        exp_blen = single ? 2'd0 : 2'd3;
        exp_id = id;
        exp_err = 1'b0;
        for (int j = 0; j < N; j++) exp_line[j] = '0;
        ph = PH_AR;
        repeat (gnt_dly) begin
            @(posedge clk);
            #1;
        end
        rd_gnt_i = 1'b1;
        @(posedge clk);
        #1;
        rd_gnt_i = 1'b0;
        ph = PH_R;
        k = 0;
        cyc = 0;
        done = 1'b0;
        fsent = 1'b0;
        while (!done) begin
            own = 1'b0;
            l = 1'b0;
            if (!fsent && fpos == k) begin
                rd_valid_i = 1'b1;
                rd_id_i = fid;
                rd_data_i = {$urandom, $urandom};
                rd_last_i = 1'($urandom_range(0, 1));
                fsent = 1'b1;
            end else if (gaps && cyc < 20 && $urandom_range(0, 3) == 0) begin
                rd_valid_i = 1'b0;
                rd_last_i = 1'($urandom_range(0, 1));
            end else begin
                own = 1'b1;
                l = (k == n - 1) ? !drop_last : (k == early);
                rd_valid_i = 1'b1;
                rd_id_i = id;
                rd_data_i = d0 + 64'(k);
                rd_last_i = l;
            end
            @(posedge clk);
            #1;
            rd_valid_i = 1'b0;
            cyc++;
            if (own) begin
                exp_line[(start + k) % N] = d0 + 64'(k);
                k++;
                if (k == n) begin
                    exp_err = exp_err | !l;
                    done = 1'b1;
                end else if (l) begin
                    exp_err = 1'b1;
                    done = 1'b1;
                end
                if (rst2 && k == 2) begin
                    reset_pulse("midrst");
                    return;
                end
            end
        end
        ph = PH_DONE;
        snap_addr = rd_addr_o;
        snap_blen = rd_blen_o;
        snap_line = line_data_o;
        snap_err = line_err_o;
        snap_model = exp_pack();
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        line_ready_i = 1'b1;
        if (poke) begin
            req_i = 1'b1;
            req_addr_i = {$urandom, $urandom};
            req_single_i = 1'($urandom_range(0, 1));
            req_id_i = 4'($urandom_range(0, 15));
        end
        @(posedge clk);
        #1;
        line_ready_i = 1'b0;
        req_i = 1'b0;
        ph = PH_IDLE;
    endtask

    initial begin
        for (int j = 0; j < N; j++) exp_line[j] = '0;
        #1;
        reset_pulse("rst0");

        // Full line, unaligned address, grant after 2 cycles.
        run_txn(64'h1008, 1'b0, 4'd3, 4'd5, 2, 99, -1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 64'hA);
        chk("t26_addr", 256'(snap_addr), 256'(64'h1000));
        chk("t26_blen", 256'(snap_blen), 256'(2'd3));
        chk("t26_line", 256'(snap_line), {64'hD, 64'hC, 64'hB, 64'hA});
        chk("t26_model", 256'(snap_model), {64'hD, 64'hC, 64'hB, 64'hA});
        chk("t26_err", 256'(snap_err), 256'(1'b0));

        // Single beat landing in word 3.
        run_txn(64'h1018, 1'b1, 4'd1, 4'd2, 0, 99, -1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 64'h55);
        chk("t27_addr", 256'(snap_addr), 256'(64'h1018));
        chk("t27_blen", 256'(snap_blen), 256'(2'd0));
        chk("t27_line", 256'(snap_line), {64'h55, 64'h0, 64'h0, 64'h0});
        chk("t27_err", 256'(snap_err), 256'(1'b0));

        // Foreign id 5 between the first and second beat.
        run_txn(64'h2000, 1'b0, 4'd3, 4'd5, 1, 1, -1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 64'hA);
        chk("t28_line", 256'(snap_line), {64'hD, 64'hC, 64'hB, 64'hA});
        chk("t28_err", 256'(snap_err), 256'(1'b0));

        // Early last on the second beat.
        run_txn(64'h3000, 1'b0, 4'd7, 4'd1, 0, 99, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 64'h100);
        chk("t29_line", 256'(snap_line), {64'h0, 64'h0, 64'h101, 64'h100});
        chk("t29_err", 256'(snap_err), 256'(1'b1));

        // Consumer stalls 5 cycles in DONE.
        run_txn(64'h4010, 1'b0, 4'd2, 4'd9, 3, 99, -1, 1'b0, 5, 1'b0, 1'b1, 1'b0, 64'hBEEF0);

        // Reset after beat 2, then idle: no line may appear.
        run_txn(64'h5000, 1'b0, 4'd4, 4'd6, 1, 99, -1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 64'h77);
        repeat (4) begin
            @(posedge clk);
            #1;
        end

        for (int t = 0; t < 200; t++) begin
            logic [3:0] id;
            bit single;
            int early;
            id = 4'($urandom_range(0, 15));
            single = ($urandom_range(0, 2) == 0);
            early = (!single && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, N - 2)) : -1;
            run_txn({$urandom, $urandom}, single, id, id ^ 4'($urandom_range(1, 15)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), early,
                    ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)), 1'b1,
                    {$urandom, $urandom});
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
